gtech_ld_bank: RTL
==================

// Module: gtech_ld_bank
// PURPOSE
//  Parametrised, clocked successor to the single-bit clearable latch primitive.
//  Holds CH independent channels, each WIDTH bits wide.
//  Each channel has an active-low gate, an active-low synchronous clear and complementary outputs.
//  An optional transparent mode gives latch-equivalent visibility.
//  A per-channel change flag with ack handshake lets control logic consume updates.
//  Used wherever generic-tech netlists need banks of gated storage in one clock domain.
// PARAMETERS
//  WIDTH       8  bits per channel (>=1)
//  CH          4  number of channels (>=1)
//  TRANSPARENT 0  0: Q is the registered value only; 1: Q = D combinationally while GN[c]=0
//  RST_VAL     0  WIDTH-bit value loaded into every channel by CD or SCDN
// PORTS
//  CP       in   1         clock, rising edge
//  CD       in   1         asynchronous clear, active-low; resets all state
//  D        in   CH*WIDTH  data; channel c = D[c*WIDTH +: WIDTH]
//  GN       in   CH        gate, active-low; GN[c]=0 enables capture into channel c
//  SCDN     in   CH        synchronous clear, active-low, per channel
//  CHG_ACK  in   CH        acknowledge; clears CHG[c]
//  Q        out  CH*WIDTH  stored value (or transparent value, see BEHAVIOUR)
//  QN       out  CH*WIDTH  bitwise ~Q, always
//  CHG      out  CH        sticky flag: channel c captured a new, different value
// BEHAVIOUR
//  - Reset
//    - CD=0 forces stored[c]=RST_VAL and CHG=0 for all channels, asynchronously.
//    - While CD=0: Q=RST_VAL and QN=~RST_VAL, even if TRANSPARENT=1.
//  - Per channel, at each CP rising edge, with CD=1, in priority order:
//    1. SCDN[c]=0: stored[c] <= RST_VAL. CHG[c] <= 0. The clear wins over GN and over an ack.
//    2. Else if GN[c]=0: stored[c] <= D[c].
//       - If D[c] != stored[c], CHG[c] <= 1.
//       - Set wins over a same-cycle CHG_ACK[c].
//    3. Else: stored[c] holds. If CHG_ACK[c]=1, CHG[c] <= 0.
//  - Capture latency: 1 cycle.
//  - Q output by mode:
//    - TRANSPARENT=0: Q[c]=stored[c].
//    - TRANSPARENT=1: Q[c] = (GN[c]==0 && CD==1) ? D[c] : stored[c].
//      - This is a zero-latency path from D to Q.
//      - SCDN does not gate this path; the clear takes effect from the next edge.
//  - Capturing the same value again does not set CHG. CHG stays set until acked or cleared.
//  - An ack with CHG[c]=0 has no effect.
//  - Channels are fully independent. Simultaneous events on different channels do not interact.
//  - CD asserted mid-operation discards pending captures and flags immediately.
//  - CD deassertion is synchronised by the integrator. After release, the first edge behaves as above.
//  - No X propagation requirement beyond standard RTL semantics. Outputs are never X after reset.
// STRUCTURE
//  - Shared package gtech_pkg:
//    - localparam helpers for channel slicing (chan_lo(c)=c*WIDTH).
//    - Mode constants GT_MODE_REG=0 and GT_MODE_TRANSP=1.
//  - One sub-module, gtech_ld_chan:
//    - A single WIDTH-bit channel: storage, CHG flag and output mux.
//    - Instantiated CH times by a generate loop.
//    - The top level only slices buses.
// TESTING (WIDTH=8, CH=4, RST_VAL=0 unless stated)
//  1. Reset and clear
//     - CD=0 with D=8'hA5 on all channels, GN=0 -> Q=0, QN=8'hFF, CHG=0.
//     - Release CD, hold GN=0 -> one cycle later Q[c]=8'hA5 and CHG=4'hF.
//  2. Hold and no-change
//     - GN[1]=1, D[1] toggles 8'h00/8'hFF -> Q[1] unchanged.
//     - GN[1]=0 with D[1]=stored value -> CHG[1] stays 0.
//  3. Handshake races
//     - CHG[2]=1, CHG_ACK[2]=1 alone -> CHG[2]=0 next cycle.
//     - Same cycle as GN[2]=0 with a new D=8'h3C -> CHG[2]=1 and Q[2]=8'h3C.
//  4. Priority
//     - SCDN[0]=0, GN[0]=0, D[0]=8'h77 together -> stored[0]=0 and CHG[0]=0.
//     - Channel 3, written the same cycle with 8'h11, gets Q[3]=8'h11.
//  5. Transparent mode
//     - TRANSPARENT=1, GN[0]=0, D[0]=8'h5A mid-cycle -> Q[0]=8'h5A with no clock.
//     - GN[0]=1 after the edge -> Q[0] holds 8'h5A.
//     - RST_VAL=8'hC3 reset -> Q=8'hC3 on all channels.
//  6. Async reset mid-stream
//     - Assert CD between edges while CHG=4'hA -> Q=0 and CHG=0 immediately.

Source files
------------

// File: rtl/gtech_pkg.sv
// Shared definitions for the generic-tech gated storage banks.
package gtech_pkg;

    // Output modes of a storage channel
    localparam int GT_MODE_REG    = 0;  // Q shows the registered value only
    localparam int GT_MODE_TRANSP = 1;  // Q follows D while the gate is open

    // Per-channel control bundle, for integrators that group the controls
    typedef struct packed {
        logic gn;    // gate, active-low
        logic scdn;  // synchronous clear, active-low
        logic ack;   // change-flag acknowledge
    } gt_ctl_t;

    // Low bit of channel c in a bus of channels, each width bits wide
    function automatic int chan_lo(input int c, input int width);
        return c * width;
    endfunction

endpackage

// File: rtl/gtech_ld_chan.sv
// One gated storage channel: stored word, sticky change flag and output mux.
module gtech_ld_chan
    import gtech_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               TRANSPARENT = GT_MODE_REG,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             cp,
    input  logic             cd,
    input  logic [WIDTH-1:0] d,
    input  logic             gn,
    input  logic             scdn,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             chg
);

    logic [WIDTH-1:0] stored;

    // Storage and change flag: clear beats capture, a new value beats an ack.
    // An ack on a cycle that sets nothing (hold, or re-capture of the same
    // value) retires the flag.
    always_ff @(posedge cp or negedge cd) begin
        if (!cd) begin
            stored <= RST_VAL;
            chg    <= 1'b0;
        end else if (!scdn) begin
            stored <= RST_VAL;
            chg    <= 1'b0;
        end else if (!gn) begin
            stored <= d;
            if (d != stored)
                chg <= 1'b1;
            else if (ack)
                chg <= 1'b0;
        end else if (ack) begin
            chg <= 1'b0;
        end
    end

    // Output mux; while CD is low stored already equals RST_VAL, so gating
    // the bypass with CD keeps Q at the reset value in both modes.
    generate
        if (TRANSPARENT == GT_MODE_TRANSP) begin : g_transp
            assign q = (!gn && cd) ? d : stored;
        end else begin : g_reg
            assign q = stored;
        end
    endgenerate

    assign qn = ~q;

endmodule

// File: rtl/gtech_ld_bank.sv
// Bank of CH independent gated storage channels sharing one clock and reset.
module gtech_ld_bank
    import gtech_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CH          = 4,
    parameter int               TRANSPARENT = GT_MODE_REG,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic                CP,
    input  logic                CD,
    input  logic [CH*WIDTH-1:0] D,
    input  logic [CH-1:0]       GN,
    input  logic [CH-1:0]       SCDN,
    input  logic [CH-1:0]       CHG_ACK,
    output logic [CH*WIDTH-1:0] Q,
    output logic [CH*WIDTH-1:0] QN,
    output logic [CH-1:0]       CHG
);

    // The top only slices buses; all behaviour lives in the channel
    generate
        for (genvar c = 0; c < CH; c++) begin : g_chan
            localparam int LO = chan_lo(c, WIDTH);
            gtech_ld_chan #(
                .WIDTH       (WIDTH),
                .TRANSPARENT (TRANSPARENT),
                .RST_VAL     (RST_VAL)
            ) u_chan (
                .cp   (CP),
                .cd   (CD),
                .d    (D[LO +: WIDTH]),
                .gn   (GN[c]),
                .scdn (SCDN[c]),
                .ack  (CHG_ACK[c]),
                .q    (Q[LO +: WIDTH]),
                .qn   (QN[LO +: WIDTH]),
                .chg  (CHG[c])
            );
        end
    endgenerate

endmodule
